// File: rtl/softmax_result_writer_if.sv
// Bus interface for softmax_result_writer: result-beat handshake from the
// softmax core plus the arbitrated single-port result RAM write port.
interface softmax_result_writer_if #(
   parameter int DATAWIDTH = 16,
   parameter int NUM       = 4,
   parameter int ADDRSIZE  = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [DATAWIDTH*NUM-1:0] in_data;
   logic                     mem_gnt;
   logic                     mem_we;
   logic [ADDRSIZE-1:0]      mem_addr;
   logic [DATAWIDTH*NUM-1:0] mem_d;

   // master: the writer itself
   modport master (
      input  in_valid, in_data, mem_gnt,
      output in_ready, mem_we, mem_addr, mem_d
   );

   // slave: softmax core / RAM arbiter side
   modport slave (
      output in_valid, in_data, mem_gnt,
      input  in_ready, mem_we, mem_addr, mem_d
   );
endinterface

// File: rtl/softmax_result_writer.sv
// softmax_result_writer: accepts packed softmax result beats and writes them
// into the result RAM at base_addr+i through a 2-entry decoupling FIFO.
// Optional feature macro: SOFTMAX_WR_CHECKSUM_EN adds an XOR checksum output
// over every word written to the RAM.
module softmax_result_writer #(
   parameter int DATAWIDTH = 16,
   parameter int NUM       = 4,
   parameter int ADDRSIZE  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [ADDRSIZE-1:0]         base_addr,
   input  logic [ADDRSIZE-1:0]         addr_limit,
   softmax_result_writer_if.master     bus,
   output logic                        busy,
   output logic                        done
`ifdef SOFTMAX_WR_CHECKSUM_EN
   ,
   output logic [DATAWIDTH*NUM-1:0]    checksum
`endif
);
   localparam int W  = DATAWIDTH * NUM;
   localparam int CW = ADDRSIZE + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDRSIZE-1:0] base_q;
   logic [ADDRSIZE-1:0] limit_q;
   logic [CW-1:0]       limit_ext;
   logic [CW-1:0]       acc_cnt;
   logic [CW-1:0]       wr_cnt;
   logic [W-1:0]        fifo_mem [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          fifo_cnt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                start_ok;

   assign limit_ext  = {1'b0, limit_q};
   assign fifo_full  = (fifo_cnt == 2'd2);
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign start_ok   = start && (state == IDLE);

   // in_ready looks at "full" only, so a pop cannot make room for a push in the same cycle
   assign bus.in_ready = (state == ACTIVE) && !fifo_full && (acc_cnt < limit_ext);
   assign bus.mem_we   = (state == ACTIVE) && !fifo_empty && bus.mem_gnt;
   assign bus.mem_addr = base_q + wr_cnt[ADDRSIZE-1:0];
   assign bus.mem_d    = fifo_mem[rd_ptr];

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.mem_we;
   assign busy = (state == ACTIVE);
   assign done = (state == DONE);

   // next-state: finish on the cycle that writes the last word
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (addr_limit == '0) ? DONE : ACTIVE;
         ACTIVE:  if (pop && ((wr_cnt + CW'(1)) == limit_ext)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // transfer parameters latched on accepted start; accept/write counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q  <= '0;
         limit_q <= '0;
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else if (start_ok) begin
         base_q  <= base_addr;
         limit_q <= addr_limit;
         acc_cnt <= '0;
         wr_cnt  <= '0;
      end else begin
         if (push) acc_cnt <= acc_cnt + CW'(1);
         if (pop)  wr_cnt  <= wr_cnt + CW'(1);
      end
   end

   // 2-entry FIFO; storage is reset so mem_d reads 0 out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.in_data;
            wr_ptr           <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

`ifdef SOFTMAX_WR_CHECKSUM_EN
   // running XOR of every word written; cleared when a transfer starts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        checksum <= '0;
      else if (start_ok) checksum <= '0;
      else if (pop)      checksum <= checksum ^ bus.mem_d;
   end
`endif

endmodule

// File: tb/tb_softmax_result_writer.sv
// Directed self-checking bench for softmax_result_writer.
module tb_softmax_result_writer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic [7:0] addr_limit = '0;
   logic       busy;
   logic       done;
`ifdef SOFTMAX_WR_CHECKSUM_EN
   logic [63:0] checksum;
`endif

   softmax_result_writer_if #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(8)) bus ();

   softmax_result_writer #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .addr_limit (addr_limit),
      .bus        (bus),
      .busy       (busy),
      .done       (done)
`ifdef SOFTMAX_WR_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [63:0] beats [8];
   logic [7:0]  wr_addr_q [$];
   logic [63:0] wr_data_q [$];
   int          wr_cyc_q  [$];
   int          acc_cyc_q [$];
   int done_cnt, done_cyc, ready_cnt, ready_gnt0_cnt, acc_gnt0_cnt, we_gnt0_cnt;
   int start_cyc;
   bit timed_out;

   // Observe the DUT mid-cycle: combinational outputs here are what the next edge commits.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_d);
            wr_cyc_q.push_back(cyc);
            if (!bus.mem_gnt) we_gnt0_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            acc_cyc_q.push_back(cyc);
            if (!bus.mem_gnt) acc_gnt0_cnt++;
         end
         if (bus.in_ready) begin
            ready_cnt++;
            if (!bus.mem_gnt) ready_gnt0_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); acc_cyc_q.delete();
      done_cnt = 0; done_cyc = -1; ready_cnt = 0; ready_gnt0_cnt = 0;
      acc_gnt0_cnt = 0; we_gnt0_cnt = 0; timed_out = 0;
   endtask

   // Start a transfer and stream beats[0..n_beats-1] until done (bounded).
   task automatic do_transfer(input logic [7:0] base, input logic [7:0] limit,
                              input int gnt_off, input int n_beats, input bit poke_start);
      int k = 0;
      int c = 0;
      clear_logs();
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; addr_limit = limit;
      bus.mem_gnt = (gnt_off == 0); bus.in_valid = 1'b0;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cnt == 0 && c < 100) begin
         bus.mem_gnt = (c >= gnt_off);
         if (poke_start && c == 1) begin
            start = 1'b1; base_addr = 8'h99; addr_limit = 8'd1;
         end else start = 1'b0;
         bus.in_valid = (k < n_beats);
         if (k < n_beats) bus.in_data = beats[k];
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) k++;
         @(posedge clk); #1;
         c++;
      end
      timed_out = (done_cnt == 0);
      bus.in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.in_valid = 1'b1; bus.mem_gnt = 1'b1; bus.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
      tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
      tests++; if (bus.mem_addr !== 8'h00) begin fails++; $display("FAIL rst_mem_addr got %h exp 00", bus.mem_addr); end
      tests++; if (bus.mem_d !== 64'h0) begin fails++; $display("FAIL rst_mem_d got %h exp 0", bus.mem_d); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
      @(negedge clk);
      reset = 1'b1; bus.in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      beats[0] = 64'h3800_4040_4210_993E;
      beats[1] = 64'h3C00_4000_4200_4400;
      beats[2] = 64'hBC00_C000_C200_C400;
      beats[3] = 64'h0001_0002_0003_0004;
      beats[4] = 64'hDEAD_BEEF_CAFE_F00D;
      do_transfer(8'h10, 8'd4, 0, 5, 1'b1);
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL b2b_timeout got %b exp 0", timed_out); end
      tests++; if (acc_cyc_q.size() !== 4) begin fails++; $display("FAIL b2b_accepts got %0d exp 4", acc_cyc_q.size()); end
      tests++; if (wr_addr_q.size() !== 4) begin fails++; $display("FAIL b2b_writes got %0d exp 4", wr_addr_q.size()); end
      for (int i = 0; i < 4 && i < wr_addr_q.size() && i < acc_cyc_q.size(); i++) begin
         tests++; if (wr_addr_q[i] !== 8'h10 + 8'(i)) begin fails++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, wr_addr_q[i], 8'h10 + 8'(i)); end
         tests++; if (wr_data_q[i] !== beats[i]) begin fails++; $display("FAIL b2b_data[%0d] got %h exp %h", i, wr_data_q[i], beats[i]); end
         tests++; if (wr_cyc_q[i] !== acc_cyc_q[i] + 1) begin fails++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, wr_cyc_q[i], acc_cyc_q[i] + 1); end
      end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL b2b_done_cnt got %0d exp 1", done_cnt); end
      if (wr_cyc_q.size() == 4) begin
         tests++; if (done_cyc !== wr_cyc_q[3] + 1) begin fails++; $display("FAIL b2b_done_cyc got %0d exp %0d", done_cyc, wr_cyc_q[3] + 1); end
      end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_gnt_stall();
      beats[0] = 64'h1111_2222_3333_4444;
      beats[1] = 64'h5555_6666_7777_8888;
      beats[2] = 64'h9999_AAAA_BBBB_CCCC;
      beats[3] = 64'hDDDD_EEEE_FFFF_0000;
      do_transfer(8'h40, 8'd4, 6, 4, 1'b0);
      tests++; if (timed_out !== 1'b0) begin fails++; $display("FAIL stall_timeout got %b exp 0", timed_out); end
      tests++; if (acc_gnt0_cnt !== 2) begin fails++; $display("FAIL stall_accepts_gnt0 got %0d exp 2", acc_gnt0_cnt); end
      tests++; if (ready_gnt0_cnt !== 2) begin fails++; $display("FAIL stall_ready_gnt0 got %0d exp 2", ready_gnt0_cnt); end
      tests++; if (we_gnt0_cnt !== 0) begin fails++; $display("FAIL stall_we_gnt0 got %0d exp 0", we_gnt0_cnt); end
      tests++; if (wr_data_q.size() !== 4) begin fails++; $display("FAIL stall_writes got %0d exp 4", wr_data_q.size()); end
      for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
         tests++; if (wr_data_q[i] !== beats[i]) begin fails++; $display("FAIL stall_data[%0d] got %h exp %h", i, wr_data_q[i], beats[i]); end
         tests++; if (wr_addr_q[i] !== 8'h40 + 8'(i)) begin fails++; $display("FAIL stall_addr[%0d] got %h exp %h", i, wr_addr_q[i], 8'h40 + 8'(i)); end
      end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL stall_done_cnt got %0d exp 1", done_cnt); end
   endtask

   task automatic test_addr_wrap();
      logic [7:0] exp_addr [4];
      exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
      for (int i = 0; i < 4; i++) beats[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      do_transfer(8'hFE, 8'd4, 0, 4, 1'b0);
      tests++; if (wr_addr_q.size() !== 4) begin fails++; $display("FAIL wrap_writes got %0d exp 4", wr_addr_q.size()); end
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
         tests++; if (wr_addr_q[i] !== exp_addr[i]) begin fails++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, wr_addr_q[i], exp_addr[i]); end
      end
   endtask

   task automatic test_zero_limit();
      beats[0] = 64'h0123_4567_89AB_CDEF;
      beats[1] = 64'hFEDC_BA98_7654_3210;
      do_transfer(8'h50, 8'd0, 0, 2, 1'b0);
      tests++; if (ready_cnt !== 0) begin fails++; $display("FAIL zero_ready got %0d exp 0", ready_cnt); end
      tests++; if (wr_addr_q.size() !== 0) begin fails++; $display("FAIL zero_writes got %0d exp 0", wr_addr_q.size()); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); end
      tests++; if (done_cyc !== start_cyc + 1) begin fails++; $display("FAIL zero_done_cyc got %0d exp %0d", done_cyc, start_cyc + 1); end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int c = 0;
      for (int i = 0; i < 4; i++) beats[i] = 64'h7700_0000_0000_0000 | 64'(i + 1);
      clear_logs();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h30; addr_limit = 8'd4; bus.mem_gnt = 1'b1; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (wr_addr_q.size() < 2 && c < 50) begin
         bus.in_valid = 1'b1; bus.in_data = beats[k];
         @(negedge clk);
         if (bus.in_ready) k++;
         @(posedge clk); #1;
         c++;
      end
      tests++; if (wr_addr_q.size() !== 2) begin fails++; $display("FAIL rmid_pre_writes got %0d exp 2", wr_addr_q.size()); end
      reset = 1'b0;
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rmid_in_ready got %b exp 0", bus.in_ready); end
      tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rmid_mem_we got %b exp 0", bus.mem_we); end
      tests++; if (bus.mem_addr !== 8'h00) begin fails++; $display("FAIL rmid_mem_addr got %h exp 00", bus.mem_addr); end
      tests++; if (bus.mem_d !== 64'h0) begin fails++; $display("FAIL rmid_mem_d got %h exp 0", bus.mem_d); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      beats[0] = 64'h0BAD_F00D_0000_0001;
      beats[1] = 64'h0BAD_F00D_0000_0002;
      do_transfer(8'h20, 8'd2, 0, 2, 1'b0);
      tests++; if (wr_addr_q.size() !== 2) begin fails++; $display("FAIL rmid_writes got %0d exp 2", wr_addr_q.size()); end
      for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
         tests++; if (wr_addr_q[i] !== 8'h20 + 8'(i)) begin fails++; $display("FAIL rmid_addr[%0d] got %h exp %h", i, wr_addr_q[i], 8'h20 + 8'(i)); end
         tests++; if (wr_data_q[i] !== beats[i]) begin fails++; $display("FAIL rmid_data[%0d] got %h exp %h", i, wr_data_q[i], beats[i]); end
      end
   endtask

`ifdef SOFTMAX_WR_CHECKSUM_EN
   task automatic test_checksum();
      beats[0] = 64'h1; beats[1] = 64'h2; beats[2] = 64'h4; beats[3] = 64'h8;
      do_transfer(8'h60, 8'd4, 0, 4, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      tests++; if (checksum !== 64'hF) begin fails++; $display("FAIL csum_value got %h exp f", checksum); end
      do_transfer(8'h70, 8'd0, 0, 0, 1'b0);
      tests++; if (checksum !== 64'h0) begin fails++; $display("FAIL csum_clear got %h exp 0", checksum); end
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.mem_gnt  = 1'b0;
      test_reset();
      test_back_to_back();
      test_gnt_stall();
      test_addr_wrap();
      test_zero_limit();
      test_reset_mid();
`ifdef SOFTMAX_WR_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
